// File: rtl/car_sensor_conditioner.sv
// ---------------------------------------------------------------------------
// car_sensor_conditioner
//
// Turns the raw side-road vehicle detector into the intersection controller's
// request X. The detector is synchronised and debounced, each debounced
// rising edge counts one waiting vehicle, and vehicles are credited as
// departed while the east-west light is green. The request is dropped once
// the queue is empty or a maximum-green budget has been spent.
//
// Ports:
//   clock       in   rising-edge clock
//   clear       in   asynchronous active-high reset
//   sensor_raw  in   asynchronous detector level, 1 = vehicle present
//   ew          in   controller east-west light (0 red, 1 yellow, 2 green,
//                    3 treated as not green)
//   X           out  request to the controller
//   car_count   out  number of vehicles waiting
//   overflow    out  sticky: an arrival was lost to counter saturation
// ---------------------------------------------------------------------------
module car_sensor_conditioner #(
  parameter int DEBOUNCE     = 4,
  parameter int CNT_W        = 4,
  parameter int SERVE_CYCLES = 8,
  parameter int MAX_GREEN    = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             sensor_raw,
  input  logic [1:0]       ew,
  output logic             X,
  output logic [CNT_W-1:0] car_count,
  output logic             overflow
);

  localparam int DEB_W   = $clog2(DEBOUNCE + 1);
  localparam int SERVE_W = $clog2(SERVE_CYCLES + 1);
  localparam int GREEN_W = $clog2(MAX_GREEN + 1);

  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE - 1);
  localparam logic [SERVE_W-1:0] SERVE_LAST = SERVE_W'(SERVE_CYCLES - 1);
  localparam logic [GREEN_W-1:0] GREEN_LAST = GREEN_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

  // Bit 1 of the encoding is the request itself, so X comes straight from one
  // flop and cannot glitch on any state change.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CUTOFF  = 2'b01,
    REQUEST = 2'b10,
    SERVE   = 2'b11
  } state_t;

  logic               sync_p0;
  logic               sync_p1;
  logic               stable;
  logic [DEB_W-1:0]   deb_cnt;
  logic               arrival;
  logic [SERVE_W-1:0] serve_tmr;
  logic               depart;
  logic [GREEN_W-1:0] green_tmr;
  state_t             state;
  state_t             state_nxt;
  logic               ew_green;
  logic               deb_accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] floor_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - CNT_W'(1);
  endfunction

  assign ew_green   = (ew == 2'd2);
  assign deb_accept = (sync_p1 != stable) && (deb_cnt == DEB_LAST);

  // Stage: two-flop synchroniser for the asynchronous detector
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= sensor_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage: debounce and arrival pulse
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      stable  <= 1'b0;
      deb_cnt <= '0;
      arrival <= 1'b0;
    end else begin
      arrival <= deb_accept && sync_p1;
      if (sync_p1 == stable) begin
        deb_cnt <= '0;
      end else if (deb_accept) begin
        stable  <= sync_p1;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  // Stage: serve timer (departure credit) and green budget timer
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      serve_tmr <= '0;
      depart    <= 1'b0;
      green_tmr <= '0;
    end else if (ew_green) begin
      if (serve_tmr == SERVE_LAST) begin
        serve_tmr <= '0;
        depart    <= 1'b1;
      end else begin
        serve_tmr <= serve_tmr + SERVE_W'(1);
        depart    <= 1'b0;
      end
      if (green_tmr != GREEN_LAST) begin
        green_tmr <= green_tmr + GREEN_W'(1);
      end
    end else begin
      serve_tmr <= '0;
      depart    <= 1'b0;
      green_tmr <= '0;
    end
  end

  // Stage: waiting-vehicle counter; a simultaneous arrival and departure
  // cancel, so neither saturation nor overflow applies in that cycle.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      car_count <= '0;
      overflow  <= 1'b0;
    end else begin
      case ({arrival, depart})
        2'b10: begin
          if (car_count == CNT_MAX) begin
            overflow <= 1'b1;
          end
          car_count <= sat_inc(car_count);
        end
        2'b01:   car_count <= floor_dec(car_count);
        default: car_count <= car_count;
      endcase
    end
  end

  // Stage: request state machine
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (car_count != '0) state_nxt = REQUEST;
      end
      REQUEST: begin
        if (car_count == '0) state_nxt = IDLE;
        else if (ew_green)   state_nxt = SERVE;
      end
      SERVE: begin
        if (car_count == '0)             state_nxt = IDLE;
        else if (!ew_green)              state_nxt = REQUEST;
        else if (green_tmr == GREEN_LAST) state_nxt = CUTOFF;
      end
      CUTOFF: begin
        if (!ew_green) state_nxt = (car_count != '0) ? REQUEST : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign X = state[1];

endmodule

// File: tb/tb_car_sensor_conditioner.sv
// ---------------------------------------------------------------------------
// tb_car_sensor_conditioner
//
// Scenario tasks drive the detector and light code and compare X, car_count
// and overflow against values derived from the block's counting rules:
// arrivals are detector highs lasting at least DEBOUNCE cycles, departures
// are one per SERVE_CYCLES consecutive green cycles (applied one edge late),
// and the request is cut after MAX_GREEN green edges.
// ---------------------------------------------------------------------------
module tb_car_sensor_conditioner;

  localparam int DEBOUNCE     = 4;
  localparam int CNT_W        = 4;
  localparam int SERVE_CYCLES = 8;
  localparam int MAX_GREEN    = 32;
  localparam int CNT_SAT      = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             clear;
  logic             sensor_raw;
  logic [1:0]       ew;
  logic             X;
  logic [CNT_W-1:0] car_count;
  logic             overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  car_sensor_conditioner #(
    .DEBOUNCE    (DEBOUNCE),
    .CNT_W       (CNT_W),
    .SERVE_CYCLES(SERVE_CYCLES),
    .MAX_GREEN   (MAX_GREEN)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .sensor_raw(sensor_raw),
    .ew        (ew),
    .X         (X),
    .car_count (car_count),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  // Advance n rising edges; return 1 time unit after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic apply_reset();
    clear      = 1'b1;
    sensor_raw = 1'b0;
    ew         = 2'd0;
    tick(2);
    clear = 1'b0;
    tick(1);
  endtask

  // Each car: detector high 6 cycles (accepted), low 6 cycles (fall accepted).
  task automatic queue_cars(input int n);
    for (int i = 0; i < n; i++) begin
      sensor_raw = 1'b1;
      tick(6);
      sensor_raw = 1'b0;
      tick(6);
    end
  endtask

  task automatic test_reset();
    clear      = 1'b1;
    sensor_raw = 1'b0;
    ew         = 2'd0;
    #3;
    n_cmp++;
    if ({X, overflow} !== 2'b00 || car_count !== '0) begin
      n_fail++;
      $display("FAIL reset_values: X=%b count=%0d ovf=%b, want 0/0/0", X, car_count, overflow);
    end
    tick(2);
    clear = 1'b0;
    tick(4);
    n_cmp++;
    if (X !== 1'b0 || car_count !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: X=%b count=%0d, want 0/0", X, car_count);
    end
  endtask

  task automatic test_debounce();
    apply_reset();
    sensor_raw = 1'b1;
    tick(DEBOUNCE - 1);
    sensor_raw = 1'b0;
    tick(12);
    n_cmp++;
    if (car_count !== '0 || X !== 1'b0) begin
      n_fail++;
      $display("FAIL short_pulse: count=%0d X=%b, want 0/0", car_count, X);
    end
    sensor_raw = 1'b1;
    tick(6);
    n_cmp++;
    if (car_count !== '0) begin
      n_fail++;
      $display("FAIL arrival_early: count=%0d after 6 edges, want 0", car_count);
    end
    tick(1);
    n_cmp++;
    if (car_count !== CNT_W'(1) || X !== 1'b0) begin
      n_fail++;
      $display("FAIL arrival_latency: count=%0d X=%b after 7 edges, want 1/0", car_count, X);
    end
    tick(1);
    n_cmp++;
    if (X !== 1'b1) begin
      n_fail++;
      $display("FAIL request_latency: X=%b after 8 edges, want 1", X);
    end
    tick(2);
    sensor_raw = 1'b0;
    tick(10);
    n_cmp++;
    if (car_count !== CNT_W'(1)) begin
      n_fail++;
      $display("FAIL falling_edge: count=%0d, want 1", car_count);
    end
  endtask

  task automatic test_service();
    int exp_cnt;
    apply_reset();
    queue_cars(2);
    n_cmp++;
    if (car_count !== CNT_W'(2) || X !== 1'b1) begin
      n_fail++;
      $display("FAIL service_queue: count=%0d X=%b, want 2/1", car_count, X);
    end
    ew = 2'd2;
    for (int k = 1; k <= 19; k++) begin
      tick(1);
      exp_cnt = 2 - (k - 1) / SERVE_CYCLES;
      if (exp_cnt < 0) exp_cnt = 0;
      n_cmp++;
      if (car_count !== CNT_W'(exp_cnt)) begin
        n_fail++;
        $display("FAIL service_count: green edge %0d count=%0d, want %0d", k, car_count, exp_cnt);
      end
      if (k == 17) begin
        n_cmp++;
        if (X !== 1'b1) begin
          n_fail++;
          $display("FAIL service_hold: X=%b at edge 17, want 1", X);
        end
      end
      if (k == 19) begin
        n_cmp++;
        if (X !== 1'b0) begin
          n_fail++;
          $display("FAIL service_drop: X=%b at edge 19, want 0", X);
        end
      end
    end
    ew = 2'd0;
    tick(2);
  endtask

  task automatic test_cutoff();
    int exp_cnt;
    logic exp_x;
    apply_reset();
    queue_cars(10);
    n_cmp++;
    if (car_count !== CNT_W'(10)) begin
      n_fail++;
      $display("FAIL cutoff_queue: count=%0d, want 10", car_count);
    end
    ew = 2'd2;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      exp_cnt = 10 - (k - 1) / SERVE_CYCLES;
      exp_x   = (k < MAX_GREEN);
      n_cmp++;
      if (car_count !== CNT_W'(exp_cnt) || X !== exp_x) begin
        n_fail++;
        $display("FAIL cutoff_green: edge %0d count=%0d X=%b, want %0d/%b", k, car_count, X, exp_cnt, exp_x);
      end
    end
    ew = 2'd0;
    tick(1);
    exp_cnt = 10 - 40 / SERVE_CYCLES;
    n_cmp++;
    if (car_count !== CNT_W'(exp_cnt) || X !== 1'b1) begin
      n_fail++;
      $display("FAIL cutoff_release: count=%0d X=%b, want %0d/1", car_count, X, exp_cnt);
    end
  endtask

  task automatic test_preempt();
    apply_reset();
    queue_cars(2);
    ew = 2'd2;
    tick(5);
    n_cmp++;
    if (car_count !== CNT_W'(2) || X !== 1'b1) begin
      n_fail++;
      $display("FAIL preempt_serve: count=%0d X=%b, want 2/1", car_count, X);
    end
    ew = 2'd0;
    tick(1);
    n_cmp++;
    if (car_count !== CNT_W'(2) || X !== 1'b1) begin
      n_fail++;
      $display("FAIL preempt_request: count=%0d X=%b, want 2/1", car_count, X);
    end
    ew = 2'd2;
    tick(SERVE_CYCLES);
    n_cmp++;
    if (car_count !== CNT_W'(2)) begin
      n_fail++;
      $display("FAIL preempt_credit_lost: count=%0d, want 2", car_count);
    end
    tick(1);
    n_cmp++;
    if (car_count !== CNT_W'(1)) begin
      n_fail++;
      $display("FAIL preempt_full_serve: count=%0d, want 1", car_count);
    end
    ew = 2'd0;
    tick(2);
  endtask

  task automatic test_random_arrivals();
    int len;
    int n_acc;
    int exp_cnt;
    apply_reset();
    n_acc = 0;
    for (int p = 0; p < 24; p++) begin
      len = $urandom_range(1, 7);
      sensor_raw = 1'b1;
      tick(len);
      sensor_raw = 1'b0;
      tick($urandom_range(8, 12));
      if (len >= DEBOUNCE) n_acc++;
      exp_cnt = (n_acc > CNT_SAT) ? CNT_SAT : n_acc;
      n_cmp++;
      if (car_count !== CNT_W'(exp_cnt) || overflow !== (n_acc > CNT_SAT) || X !== (exp_cnt != 0)) begin
        n_fail++;
        $display("FAIL random_arrival: pulse %0d len %0d count=%0d ovf=%b X=%b, want %0d/%b/%b",
                 p, len, car_count, overflow, X, exp_cnt, (n_acc > CNT_SAT), (exp_cnt != 0));
      end
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    queue_cars(CNT_SAT);
    n_cmp++;
    if (car_count !== CNT_W'(CNT_SAT) || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_fill: count=%0d ovf=%b, want %0d/0", car_count, overflow, CNT_SAT);
    end
    // Align an arrival with the first departure credit: green starts two
    // edges before the detector is first sampled high.
    ew = 2'd2;
    tick(2);
    sensor_raw = 1'b1;
    tick(6);
    sensor_raw = 1'b0;
    tick(1);
    n_cmp++;
    if (car_count !== CNT_W'(CNT_SAT) || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_coincident: count=%0d ovf=%b, want %0d/0", car_count, overflow, CNT_SAT);
    end
    ew = 2'd0;
    tick(8);
    queue_cars(1);
    n_cmp++;
    if (car_count !== CNT_W'(CNT_SAT) || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_overflow: count=%0d ovf=%b, want %0d/1", car_count, overflow, CNT_SAT);
    end
  endtask

  task automatic test_async_clear();
    #2;
    clear = 1'b1;
    #1;
    n_cmp++;
    if (X !== 1'b0 || car_count !== '0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL async_clear: X=%b count=%0d ovf=%b, want 0/0/0", X, car_count, overflow);
    end
    tick(2);
    clear = 1'b0;
    tick(4);
    n_cmp++;
    if (X !== 1'b0 || car_count !== '0) begin
      n_fail++;
      $display("FAIL clear_discard: X=%b count=%0d, want 0/0", X, car_count);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_service();
    test_cutoff();
    test_preempt();
    test_random_arrivals();
    test_saturation();
    test_async_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
